// File: rtl/mb_maths_pkg.sv
// Package shared by the mb_maths pipeline files.
//
// Contents:
//   mbMode_e      operation select carried with each sample
//                 (MB_ADD = x+y, MB_SUB = x-y)
//   MB_MAX_W      widest intermediate the range helper can evaluate
//   mbSumWidth    width of the exact add/subtract result
//   mbProdWidth   width of the exact product
//   mbInRange     narrowing helper: does a shifted product fit in w signed bits
package mb_maths_pkg;

  typedef enum logic {
    MB_ADD = 1'b0,
    MB_SUB = 1'b1
  } mbMode_e;

  localparam int MB_MAX_W = 64;

  // One guard bit keeps x +/- y exact.
  function automatic int mbSumWidth(input int w);
    return w + 1;
  endfunction

  // The product of a (w+1)-bit and an mw-bit signed value needs w+1+mw bits.
  function automatic int mbProdWidth(input int w, input int mw);
    return w + 1 + mw;
  endfunction

  // Only the bound on the value's own side can be violated, so the sign
  // selects which single limit is checked.
  function automatic logic mbInRange(input logic signed [MB_MAX_W-1:0] val,
                                     input int w,
                                     input logic isNeg);
    logic signed [MB_MAX_W-1:0] lim;
    if (isNeg) begin
      lim = -(64'sd1 <<< (w - 1));
      return val >= lim;
    end else begin
      lim = (64'sd1 <<< (w - 1)) - 64'sd1;
      return val <= lim;
    end
  endfunction

endpackage

// File: rtl/mb_maths_pipe_stage.sv
// One elastic valid/ready register slice of the mb_maths pipeline.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset, clears valid and data
//   inValid_i   upstream has data
//   inData_i    upstream data, DW bits
//   inReady_o   slice accepts data this cycle
//   outValid_o  slice holds data
//   outData_o   held data, stable until taken
//   outReady_i  downstream takes the held data this cycle
module mb_pipe_stage
  import mb_maths_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inValid_i,
  input  logic [DW-1:0] inData_i,
  output logic          inReady_o,
  output logic          outValid_o,
  output logic [DW-1:0] outData_o,
  input  logic          outReady_i
);

  logic          valid_q;
  logic          valid_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;
  logic          load;

  // The slice can take new data when it is empty or when its current
  // content leaves this same cycle, so a full pipe still streams at one
  // item per cycle and empty slots (bubbles) are filled immediately.
  assign inReady_o  = !valid_q | outReady_i;
  assign load       = inValid_i & inReady_o;
  assign outValid_o = valid_q;
  assign outData_o  = data_q;

  // Next-state: load wins over drain; data only changes on a load, which
  // keeps the output stable while the consumer is stalling.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = inData_i;
    end else if (outReady_i) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous reset discarding any held item.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mb_maths_pipe.sv
// Elastic 3-stage signed maths pipeline:
//   v = ((x +/- y) * M_VAL) >>> SHIFT, narrowed to W bits.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   x, y       signed W-bit operands
//   mode       0 = x+y, 1 = x-y (sampled with x/y)
//   in_valid   operands valid          in_ready   pipe accepts operands
//   v          signed W-bit result     ovf        result did not fit W bits
//   out_valid  v/ovf valid             out_ready  consumer takes result
//   busy       some stage holds an item
//
// Build option: define MB_MATHS_SAT_EN to clamp out-of-range results to the
// W-bit signed limits; otherwise they wrap (two's complement). ovf flags
// either case.
module mb_maths_pipe
  import mb_maths_pkg::*;
#(
  parameter int W     = 16,
  parameter int M_VAL = 10,
  parameter int MW    = 8,
  parameter int SHIFT = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] v,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int SW = mbSumWidth(W);
  localparam int PW = mbProdWidth(W, MW);
  localparam logic [MW-1:0] M_BITS = MW'(M_VAL);

  // Reject parameter sets the datapath cannot represent.
  if (W < 4 || PW >= MB_MAX_W) begin : gBadWidth
    $error("mb_maths_pipe: W out of supported range");
  end
  if (M_VAL > ((1 <<< (MW - 1)) - 1) || M_VAL < -(1 <<< (MW - 1))) begin : gBadMul
    $error("mb_maths_pipe: M_VAL does not fit in MW signed bits");
  end
  if (SHIFT < 0 || SHIFT > W) begin : gBadShift
    $error("mb_maths_pipe: SHIFT must be within 0..W");
  end

  // Stage 1: add/subtract. Subtraction is x + ~y + 1; the +1 travels as a
  // carry bit alongside the partial sum and is folded in at stage 2, so the
  // stage-1 adder never needs a carry-in and the sum is still exact.
  logic [SW-1:0] xExt;
  logic [SW-1:0] yExt;
  logic [SW-1:0] partialD;
  logic          isSub;
  logic [SW:0]   s1Out;
  logic          s1Valid;
  logic          s2Ready;

  assign xExt     = {x[W-1], x};
  assign yExt     = {y[W-1], y};
  assign isSub    = (mbMode_e'(mode) == MB_SUB);
  assign partialD = xExt + (isSub ? ~yExt : yExt);

  mb_pipe_stage #(.DW(SW + 1)) uStage1 (
    .clock      (clock),
    .reset      (reset),
    .inValid_i  (in_valid),
    .inData_i   ({isSub, partialD}),
    .inReady_o  (in_ready),
    .outValid_o (s1Valid),
    .outData_o  (s1Out),
    .outReady_i (s2Ready)
  );

  // Stage 2: exact product. Both operands are sign-extended to the product
  // width so the low PW bits of the multiply are the signed result; the
  // product sign rides along to steer clamping in stage 3.
  logic [SW-1:0] sumFull;
  logic [PW-1:0] sumExt;
  logic [PW-1:0] mulExt;
  logic [PW-1:0] prodD;
  logic [PW:0]   s2Out;
  logic          s2Valid;
  logic          s3Ready;

  assign sumFull = s1Out[SW-1:0] + {{(SW-1){1'b0}}, s1Out[SW]};
  assign sumExt  = {{MW{sumFull[SW-1]}}, sumFull};
  assign mulExt  = {{SW{M_BITS[MW-1]}}, M_BITS};
  assign prodD   = sumExt * mulExt;

  mb_pipe_stage #(.DW(PW + 1)) uStage2 (
    .clock      (clock),
    .reset      (reset),
    .inValid_i  (s1Valid),
    .inData_i   ({prodD[PW-1], prodD}),
    .inReady_o  (s2Ready),
    .outValid_o (s2Valid),
    .outData_o  (s2Out),
    .outReady_i (s3Ready)
  );

  // Stage 3: arithmetic shift, then narrow to W bits with overflow flag.
  logic signed [PW-1:0] sh;
  logic                 shNeg;
  logic                 fits;
  logic [W-1:0]         vNarrow;
  logic [W:0]           s3Out;

  assign sh    = $signed(s2Out[PW-1:0]) >>> SHIFT;
  assign shNeg = s2Out[PW];
  assign fits  = mbInRange(longint'(sh), W, shNeg);

`ifdef MB_MATHS_SAT_EN
  localparam logic [W-1:0] V_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] V_MIN = {1'b1, {(W-1){1'b0}}};
  assign vNarrow = fits ? sh[W-1:0] : (shNeg ? V_MIN : V_MAX);
`else
  assign vNarrow = sh[W-1:0];
`endif

  mb_pipe_stage #(.DW(W + 1)) uStage3 (
    .clock      (clock),
    .reset      (reset),
    .inValid_i  (s2Valid),
    .inData_i   ({!fits, vNarrow}),
    .inReady_o  (s3Ready),
    .outValid_o (out_valid),
    .outData_o  (s3Out),
    .outReady_i (out_ready)
  );

  assign v    = s3Out[W-1:0];
  assign ovf  = s3Out[W];
  assign busy = s1Valid | s2Valid | out_valid;

endmodule
